// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the keypad-to-Hack keyboard bridge:
//   the bridge FSM states, the keypad index to Hack keycode table, and the
//   "no key" value shown on KBD.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } kbd_state_t;

    localparam logic [15:0] KBD_NONE = 16'd0;

    // Keypad layout, row*4+col:  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    localparam logic [7:0] KEY_CODES [0:15] = '{
        8'd49, 8'd50, 8'd51, 8'd65,
        8'd52, 8'd53, 8'd54, 8'd66,
        8'd55, 8'd56, 8'd57, 8'd67,
        8'd42, 8'd48, 8'd35, 8'd68
    };

    function automatic logic [15:0] key_to_code(input logic [3:0] key_index);
        return {8'd0, KEY_CODES[key_index]};
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo
//   Synchronous FIFO of 16-bit keycodes. When full, a push is still accepted
//   if a pop happens on the same edge (the pop frees the slot first).
//   Ports:
//     CLK, RESET_N   clock, synchronous active-low reset
//     push, wdata    write request and data (ignored when full without pop)
//     pop, rdata     read request; rdata is the current head (fall-through)
//     full, empty    occupancy flags
//     count          occupancy, 0..DEPTH (registered)
module keypad_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     push,
    input  logic [15:0]              wdata,
    input  logic                     pop,
    output logic [15:0]              rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/keypad_kbd_bridge.sv
// keypad_kbd_bridge
//   Turns single-cycle keypad scanner events into the Hack KBD word. Events
//   are mapped to keycodes and queued; the head is shown on KBD for
//   HOLD_CYCLES, then KBD reads 0 for GAP_CYCLES so repeated keys stay
//   distinguishable to the CPU.
//   Optional build macro: KEYPAD_ACK_EN adds ACK, which ends SHOW early.
//   Ports:
//     CLK, RESET_N          clock, synchronous active-low reset
//     KEY_INDEX, KEY_VALID  scanner event (row*4+col) and its strobe
//     ACK                   (KEYPAD_ACK_EN only) CPU consumed the key
//     KBD                   Hack keyboard word, 0 = no key
//     PENDING               queued events, including the one on KBD
//     OVERFLOW              sticky: an event was dropped on a full queue
//
//   state | meaning
//   IDLE  | KBD=0, waiting for a queued key
//   SHOW  | head keycode on KBD, counting HOLD_CYCLES
//   GAP   | KBD=0, counting GAP_CYCLES before the next key
module keypad_kbd_bridge
    import keypad_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50000,
    parameter int GAP_CYCLES  = 5000
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [3:0]               KEY_INDEX,
    input  logic                     KEY_VALID,
`ifdef KEYPAD_ACK_EN
    input  logic                     ACK,
`endif
    output logic [15:0]              KBD,
    output logic [$clog2(DEPTH):0]   PENDING,
    output logic                     OVERFLOW
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    kbd_state_t  state;
    logic [15:0] cnt;
    logic [15:0] head_code;
    logic        fifo_full;
    logic        fifo_empty;
    logic        ack_hit;
    logic        show_done;

`ifdef KEYPAD_ACK_EN
    assign ack_hit = ACK;
`else
    assign ack_hit = 1'b0;
`endif

    // The head stays queued while shown; it is popped on the edge leaving SHOW.
    assign show_done = (state == SHOW) && ((cnt == HOLD_LAST) || ack_hit);

    keypad_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (KEY_VALID),
        .wdata   (key_to_code(KEY_INDEX)),
        .pop     (show_done),
        .rdata   (head_code),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (PENDING)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            OVERFLOW <= 1'b0;
        end else if (KEY_VALID && fifo_full && !show_done) begin
            OVERFLOW <= 1'b1;
        end
    end

    // Counter compares by equality only, so it cannot wrap past its limit.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
            KBD   <= KBD_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        KBD   <= head_code;
                        cnt   <= '0;
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (show_done) begin
                        KBD   <= KBD_NONE;
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    KBD   <= KBD_NONE;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_kbd_bridge.sv
// tb_keypad_kbd_bridge
//   Self-checking bench for keypad_kbd_bridge. A behavioural model (queue of
//   keycodes plus remaining show/gap time) is stepped on every clock edge and
//   compared with KBD, PENDING and OVERFLOW; directed scenarios add explicit
//   checks against fixed values.
module tb_keypad_kbd_bridge;

    localparam int DEPTH = 4;
    localparam int HOLD  = 6;
    localparam int GAP   = 3;
    localparam int PW    = $clog2(DEPTH) + 1;
`ifdef KEYPAD_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [3:0]    key_index;
    logic          key_valid;
    logic          ack;
    logic [15:0]   kbd;
    logic [PW-1:0] pending;
    logic          overflow;

    int n_checks;
    int n_pass;

    int code_tbl [16] = '{49, 50, 51, 65, 52, 53, 54, 66,
                          55, 56, 57, 67, 42, 48, 35, 68};

    // reference model
    int q [$];
    int m_show;
    int m_gap;
    int m_kbd;
    bit m_ovf;

    keypad_kbd_bridge #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .KEY_INDEX (key_index),
        .KEY_VALID (key_valid),
`ifdef KEYPAD_ACK_EN
        .ACK       (ack),
`endif
        .KBD       (kbd),
        .PENDING   (pending),
        .OVERFLOW  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_edge(input bit v, input int idx, input bit r, input bit a);
        int  sz;
        bit  pop;
        if (!r) begin
            q.delete();
            m_show = 0;
            m_gap  = 0;
            m_kbd  = 0;
            m_ovf  = 1'b0;
            return;
        end
        sz  = q.size();
        pop = 1'b0;
        if (m_show > 0) begin
            m_show--;
            if (a && ACK_EN) m_show = 0;
            if (m_show == 0) begin
                pop   = 1'b1;
                m_kbd = 0;
                m_gap = GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (sz > 0) begin
            m_kbd  = q[0];
            m_show = HOLD;
        end
        if (pop) void'(q.pop_front());
        if (v) begin
            if (sz < DEPTH || pop) q.push_back(code_tbl[idx]);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input bit v, input int idx, input bit r, input bit a);
        @(negedge clk);
        key_valid = v;
        key_index = idx[3:0];
        rst_n     = r;
        ack       = a;
        @(posedge clk);
        model_edge(v, idx, r, a);
        #1;
        chk_val("kbd", int'(kbd), m_kbd);
        chk_val("pending", int'(pending), q.size());
        chk_val("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_key(input string tag);
        for (int i = 0; i < 60 && kbd == 16'd0; i++) idle(1);
        chk_val(tag, int'(kbd != 16'd0), 1);
    endtask

    initial begin
        int cnt;
        int windows;
        int zrun;
        int min_gap;
        int prev;
        int seen [$];

        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_index = 4'd0;
        ack       = 1'b0;
        q.delete();
        m_show = 0; m_gap = 0; m_kbd = 0; m_ovf = 1'b0;

        // reset values
        do_reset();
        chk_val("rst_kbd", int'(kbd), 0);
        chk_val("rst_pending", int'(pending), 0);
        chk_val("rst_overflow", int'(overflow), 0);

        // single key 5: latency 2, hold window, then gap
        step(1'b1, 5, 1'b1, 1'b0);
        chk_val("lat1_kbd", int'(kbd), 0);
        chk_val("lat1_pending", int'(pending), 1);
        step(1'b0, 0, 1'b1, 1'b0);
        chk_val("lat2_kbd", int'(kbd), 53);
        cnt = 1;
        for (int i = 0; i < HOLD + GAP + 2; i++) begin
            idle(1);
            if (kbd == 16'd53) cnt++;
        end
        chk_val("hold_len", cnt, HOLD);
        chk_val("drain_pending", int'(pending), 0);

        // every index once, paced so the queue never fills
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i, 1'b1, 1'b0);
            wait_key("map_wait");
            chk_val("map_code", int'(kbd), code_tbl[i]);
            idle(HOLD + GAP);
        end

        // same key twice back-to-back
        do_reset();
        step(1'b1, 13, 1'b1, 1'b0);
        step(1'b1, 13, 1'b1, 1'b0);
        windows = 0; zrun = 0; min_gap = 1000; prev = 0;
        for (int i = 0; i < 2 * (HOLD + GAP + 1) + 4; i++) begin
            idle(1);
            if (kbd == 16'd0) zrun++;
            else if (prev == 0) begin
                if (windows > 0 && zrun < min_gap) min_gap = zrun;
                windows++;
                zrun = 0;
            end
            prev = int'(kbd);
        end
        chk_val("repeat_windows", windows, 2);
        chk_val("repeat_gap_ok", int'(min_gap >= GAP), 1);

        // overflow: 6 events while the first key is being shown
        do_reset();
        step(1'b1, 0, 1'b1, 1'b0);
        wait_key("ovf_wait");
        for (int i = 1; i < 6; i++) step(1'b1, i, 1'b1, 1'b0);
        chk_val("ovf_pending", int'(pending), 4);
        chk_val("ovf_flag", int'(overflow), 1);
        seen.delete();
        seen.push_back(int'(kbd));
        prev = int'(kbd);
        for (int i = 0; i < 5 * (HOLD + GAP + 1); i++) begin
            idle(1);
            if (kbd != 16'd0 && prev == 0) seen.push_back(int'(kbd));
            prev = int'(kbd);
        end
        chk_val("ovf_count", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk_val("ovf_code", seen[i], code_tbl[i]);

        // push on the pop edge with the queue full
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, i + 4, 1'b1, 1'b0);
        for (int i = 0; i < 40 && m_show != 1; i++) idle(1);
        chk_val("pop_edge_reached", m_show, 1);
        chk_val("pop_edge_full", int'(pending), 4);
        step(1'b1, 9, 1'b1, 1'b0);
        chk_val("pop_push_pending", int'(pending), 4);
        chk_val("pop_push_ovf", int'(overflow), 0);
        chk_val("pop_push_kbd", int'(kbd), 0);

        // reset mid-SHOW with 3 pending
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, i + 8, 1'b1, 1'b0);
        idle(1);
        chk_val("mid_show_kbd", int'(kbd), 55);
        step(1'b0, 0, 1'b0, 1'b0);
        chk_val("mid_rst_kbd", int'(kbd), 0);
        chk_val("mid_rst_pending", int'(pending), 0);
        chk_val("mid_rst_ovf", int'(overflow), 0);

`ifdef KEYPAD_ACK_EN
        // ACK in the third SHOW cycle ends the window early
        do_reset();
        step(1'b1, 15, 1'b1, 1'b0);
        wait_key("ack_wait");
        idle(2);
        step(1'b0, 0, 1'b1, 1'b1);
        chk_val("ack_kbd", int'(kbd), 0);
        chk_val("ack_pending", int'(pending), 0);
`endif

        // randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 5) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 499) != 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
